// File: rtl/mc_ctrl_if.sv
// Control-unit bundle: instruction/memory status in from the datapath,
// datapath steering and strobes out, plus state, illegal flag and retire count.
interface mc_ctrl_if #(
    parameter int ALUOP_W = 3,
    parameter int CNT_W   = 32
);
    logic [5:0]         opcode;
    logic               zero;
    logic               mem_ready;

    logic               pc_write;
    logic [1:0]         pc_src;
    logic               ir_write;
    logic               i_or_d;
    logic               mem_read;
    logic               mem_write;
    logic               reg_dst;
    logic               mem_to_reg;
    logic               reg_write;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [ALUOP_W-1:0] alu_op;
    logic               ext_op;
    logic [2:0]         state;
    logic               illegal;
    logic [CNT_W-1:0]   retired;

    modport master (
        output opcode, zero, mem_ready,
        input  pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
               alu_op, ext_op, state, illegal, retired
    );

    modport slave (
        input  opcode, zero, mem_ready,
        output pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
               alu_op, ext_op, state, illegal, retired
    );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM (IF/ID/EX/MEM/WB) with ready-handshaked memory,
// illegal-opcode pulse and a wrapping retired-instruction counter.
module mc_ctrl #(
    parameter int ALUOP_W = 3,
    parameter int CNT_W   = 32
) (
    input logic      clk,
    input logic      rst,
    mc_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             retire;

    logic       pcWrite, irWrite, iOrD, memRead, memWrite;
    logic       regDst, memToReg, regWrite, aluSrcA, extOp, illegalOp;
    logic [1:0] pcSrc, aluSrcB;
    logic [2:0] aluOp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IF;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        retire    = 1'b0;
        pcWrite   = 1'b0;
        pcSrc     = 2'b00;
        irWrite   = 1'b0;
        iOrD      = 1'b0;
        memRead   = 1'b0;
        memWrite  = 1'b0;
        regDst    = 1'b0;
        memToReg  = 1'b0;
        regWrite  = 1'b0;
        aluSrcA   = 1'b0;
        aluSrcB   = 2'b00;
        aluOp     = 3'b000;
        extOp     = 1'b0;
        illegalOp = 1'b0;

        case (state_q)
            S_IF: begin
                memRead = 1'b1;
                aluSrcB = 2'b01;
                aluOp   = 3'b010;
                if (bus.mem_ready) begin
                    irWrite = 1'b1;
                    pcWrite = 1'b1;
                    state_d = S_ID;
                end
            end
            // Branch target is precomputed into ALUOut here for every opcode.
            S_ID: begin
                aluSrcB = 2'b11;
                extOp   = 1'b1;
                aluOp   = 3'b010;
                case (bus.opcode)
                    OP_J: begin
                        pcWrite = 1'b1;
                        pcSrc   = 2'b10;
                        retire  = 1'b1;
                        state_d = S_IF;
                    end
                    OP_RTYPE, OP_ADDI, OP_ADDIU, OP_ORI, OP_LUI,
                    OP_LW, OP_SW, OP_BEQ: state_d = S_EX;
                    default: begin
                        illegalOp = 1'b1;
                        state_d   = S_IF;
                    end
                endcase
            end
            S_EX: begin
                aluSrcA = 1'b1;
                state_d = S_WB;
                case (bus.opcode)
                    OP_RTYPE: begin
                        aluSrcB = 2'b00;
                        aluOp   = 3'b000;
                    end
                    OP_ADDI, OP_ADDIU: begin
                        aluSrcB = 2'b10;
                        extOp   = 1'b1;
                        aluOp   = 3'b010;
                    end
                    OP_ORI: begin
                        aluSrcB = 2'b10;
                        aluOp   = 3'b001;
                    end
                    OP_LUI: begin
                        aluSrcB = 2'b10;
                        aluOp   = 3'b100;
                    end
                    OP_LW, OP_SW: begin
                        aluSrcB = 2'b10;
                        extOp   = 1'b1;
                        aluOp   = 3'b010;
                        state_d = S_MEM;
                    end
                    OP_BEQ: begin
                        aluOp   = 3'b110;
                        pcSrc   = 2'b01;
                        pcWrite = bus.zero;
                        retire  = 1'b1;
                        state_d = S_IF;
                    end
                    default: state_d = S_IF;
                endcase
            end
            S_MEM: begin
                iOrD     = 1'b1;
                memRead  = (bus.opcode == OP_LW);
                memWrite = (bus.opcode == OP_SW);
                if (bus.mem_ready) begin
                    if (bus.opcode == OP_SW) begin
                        retire  = 1'b1;
                        state_d = S_IF;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                regWrite = 1'b1;
                regDst   = (bus.opcode == OP_RTYPE);
                memToReg = (bus.opcode == OP_LW);
                retire   = 1'b1;
                state_d  = S_IF;
            end
            default: state_d = S_IF;
        endcase

        retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
    end

    // Reset gates every output so the IF strobes cannot leak while rst is held.
    assign bus.pc_write   = pcWrite   & ~rst;
    assign bus.pc_src     = pcSrc     & {2{~rst}};
    assign bus.ir_write   = irWrite   & ~rst;
    assign bus.i_or_d     = iOrD      & ~rst;
    assign bus.mem_read   = memRead   & ~rst;
    assign bus.mem_write  = memWrite  & ~rst;
    assign bus.reg_dst    = regDst    & ~rst;
    assign bus.mem_to_reg = memToReg  & ~rst;
    assign bus.reg_write  = regWrite  & ~rst;
    assign bus.alu_src_a  = aluSrcA   & ~rst;
    assign bus.alu_src_b  = aluSrcB   & {2{~rst}};
    assign bus.alu_op     = ALUOP_W'(aluOp & {3{~rst}});
    assign bus.ext_op     = extOp     & ~rst;
    assign bus.illegal    = illegalOp & ~rst;
    assign bus.state      = state_q;
    assign bus.retired    = retired_q;
endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: per-cycle expectations are queued as stimulus is
// driven and checked against a 32-bit and a 2-bit counter instance.
module tb_mc_ctrl;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mc_ctrl_if #(.ALUOP_W(3), .CNT_W(32)) ifc ();
    mc_ctrl_if #(.ALUOP_W(3), .CNT_W(2))  ifc2 ();

    assign ifc2.opcode    = ifc.opcode;
    assign ifc2.zero      = ifc.zero;
    assign ifc2.mem_ready = ifc.mem_ready;

    mc_ctrl #(.ALUOP_W(3), .CNT_W(32)) dut  (.clk(clk), .rst(rst), .bus(ifc));
    mc_ctrl #(.ALUOP_W(3), .CNT_W(2))  dut2 (.clk(clk), .rst(rst), .bus(ifc2));

    localparam logic [5:0] OP_R     = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BAD   = 6'b111111;

    typedef struct packed {
        logic       pcWrite;
        logic [1:0] pcSrc;
        logic       irWrite;
        logic       iOrD;
        logic       memRead;
        logic       memWrite;
        logic       regDst;
        logic       memToReg;
        logic       regWrite;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [2:0] aluOp;
        logic       extOp;
        logic       illegal;
    } ctrl_t;

    typedef struct packed {
        logic [2:0]  state;
        ctrl_t       ctrl;
        logic [31:0] retired;
    } exp_t;

    exp_t        expQ[$];
    string       tagQ[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] expRet   = '0;

    function automatic ctrl_t cIF(input bit rdy);
        ctrl_t c = '0;
        c.memRead = 1'b1;
        c.aluSrcB = 2'b01;
        c.aluOp   = 3'b010;
        c.irWrite = rdy;
        c.pcWrite = rdy;
        return c;
    endfunction

    function automatic ctrl_t cID(input bit jmp, input bit ill);
        ctrl_t c = '0;
        c.aluSrcB = 2'b11;
        c.extOp   = 1'b1;
        c.aluOp   = 3'b010;
        c.pcWrite = jmp;
        c.pcSrc   = jmp ? 2'b10 : 2'b00;
        c.illegal = ill;
        return c;
    endfunction

    function automatic ctrl_t cEX(input logic [1:0] srcB, input logic [2:0] op, input bit ext);
        ctrl_t c = '0;
        c.aluSrcA = 1'b1;
        c.aluSrcB = srcB;
        c.aluOp   = op;
        c.extOp   = ext;
        return c;
    endfunction

    function automatic ctrl_t cBEQ(input bit z);
        ctrl_t c = cEX(2'b00, 3'b110, 1'b0);
        c.pcSrc   = 2'b01;
        c.pcWrite = z;
        return c;
    endfunction

    function automatic ctrl_t cMEM(input bit rd, input bit wr);
        ctrl_t c = '0;
        c.iOrD     = 1'b1;
        c.memRead  = rd;
        c.memWrite = wr;
        return c;
    endfunction

    function automatic ctrl_t cWB(input bit rd, input bit m2r);
        ctrl_t c = '0;
        c.regWrite = 1'b1;
        c.regDst   = rd;
        c.memToReg = m2r;
        return c;
    endfunction

    function automatic ctrl_t sampleCtrl();
        ctrl_t c;
        c.pcWrite  = ifc.pc_write;
        c.pcSrc    = ifc.pc_src;
        c.irWrite  = ifc.ir_write;
        c.iOrD     = ifc.i_or_d;
        c.memRead  = ifc.mem_read;
        c.memWrite = ifc.mem_write;
        c.regDst   = ifc.reg_dst;
        c.memToReg = ifc.mem_to_reg;
        c.regWrite = ifc.reg_write;
        c.aluSrcA  = ifc.alu_src_a;
        c.aluSrcB  = ifc.alu_src_b;
        c.aluOp    = ifc.alu_op;
        c.extOp    = ifc.ext_op;
        c.illegal  = ifc.illegal;
        return c;
    endfunction

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic applyStimulus(input logic r, input logic [5:0] op, input logic z, input logic rdy);
        @(negedge clk);
        rst           = r;
        ifc.opcode    = op;
        ifc.zero      = z;
        ifc.mem_ready = rdy;
        #1;
    endtask

    task automatic checkOutput();
        exp_t  e;
        string tag;
        ctrl_t act;
        e   = expQ.pop_front();
        tag = tagQ.pop_front();
        act = sampleCtrl();

        checks++;
        assert (ifc.state === e.state) else begin
            failures++;
            $error("[TB] FAIL %s.state observed=%0d expected=%0d", tag, ifc.state, e.state);
        end
        checks++;
        assert (act === e.ctrl) else begin
            failures++;
            $error("[TB] FAIL %s.ctrl observed=%h expected=%h", tag, act, e.ctrl);
        end
        checks++;
        assert (ifc.retired === e.retired) else begin
            failures++;
            $error("[TB] FAIL %s.retired observed=%0d expected=%0d", tag, ifc.retired, e.retired);
        end
        checks++;
        assert (ifc2.retired === e.retired[1:0]) else begin
            failures++;
            $error("[TB] FAIL %s.retired2 observed=%0d expected=%0d", tag, ifc2.retired, e.retired[1:0]);
        end
    endtask

    task automatic step(input logic r, input logic [5:0] op, input logic z, input logic rdy,
                        input string tag, input logic [2:0] st, input ctrl_t c, input bit retires);
        applyStimulus(r, op, z, rdy);
        if (r) expRet = '0;
        expQ.push_back('{st, c, expRet});
        tagQ.push_back(tag);
        checkOutput();
        if (retires) expRet = expRet + 32'd1;
    endtask

    initial begin
        rst           = 1'b1;
        ifc.opcode    = OP_R;
        ifc.zero      = 1'b0;
        ifc.mem_ready = 1'b1;

        step(1, OP_R, 0, 1, "rst0", 3'd0, '0, 0);
        step(1, OP_R, 1, 1, "rst1", 3'd0, '0, 0);

        // R-type, mem_ready low where it must be ignored
        step(0, OP_R, 0, 1, "R.IF", 3'd0, cIF(1), 0);
        step(0, OP_R, 0, 0, "R.ID", 3'd1, cID(0, 0), 0);
        step(0, OP_R, 1, 0, "R.EX", 3'd2, cEX(2'b00, 3'b000, 0), 0);
        step(0, OP_R, 0, 0, "R.WB", 3'd4, cWB(1, 0), 1);

        step(0, OP_ADDI, 0, 1, "ADDI.IF", 3'd0, cIF(1), 0);
        step(0, OP_ADDI, 0, 1, "ADDI.ID", 3'd1, cID(0, 0), 0);
        step(0, OP_ADDI, 0, 1, "ADDI.EX", 3'd2, cEX(2'b10, 3'b010, 1), 0);
        step(0, OP_ADDI, 0, 1, "ADDI.WB", 3'd4, cWB(0, 0), 1);

        step(0, OP_ADDIU, 0, 1, "ADDIU.IF", 3'd0, cIF(1), 0);
        step(0, OP_ADDIU, 0, 1, "ADDIU.ID", 3'd1, cID(0, 0), 0);
        step(0, OP_ADDIU, 0, 1, "ADDIU.EX", 3'd2, cEX(2'b10, 3'b010, 1), 0);
        step(0, OP_ADDIU, 0, 1, "ADDIU.WB", 3'd4, cWB(0, 0), 1);

        step(0, OP_ORI, 0, 1, "ORI.IF", 3'd0, cIF(1), 0);
        step(0, OP_ORI, 0, 1, "ORI.ID", 3'd1, cID(0, 0), 0);
        step(0, OP_ORI, 0, 1, "ORI.EX", 3'd2, cEX(2'b10, 3'b001, 0), 0);
        step(0, OP_ORI, 0, 1, "ORI.WB", 3'd4, cWB(0, 0), 1);

        step(0, OP_LUI, 0, 1, "LUI.IF", 3'd0, cIF(1), 0);
        step(0, OP_LUI, 0, 1, "LUI.ID", 3'd1, cID(0, 0), 0);
        step(0, OP_LUI, 0, 1, "LUI.EX", 3'd2, cEX(2'b10, 3'b100, 0), 0);
        step(0, OP_LUI, 0, 1, "LUI.WB", 3'd4, cWB(0, 0), 1);

        // LW with two MEM wait states: 7 cycles total
        step(0, OP_LW, 0, 1, "LW.IF", 3'd0, cIF(1), 0);
        step(0, OP_LW, 0, 1, "LW.ID", 3'd1, cID(0, 0), 0);
        step(0, OP_LW, 0, 1, "LW.EX", 3'd2, cEX(2'b10, 3'b010, 1), 0);
        step(0, OP_LW, 0, 0, "LW.MEMw1", 3'd3, cMEM(1, 0), 0);
        step(0, OP_LW, 0, 0, "LW.MEMw2", 3'd3, cMEM(1, 0), 0);
        step(0, OP_LW, 0, 1, "LW.MEM", 3'd3, cMEM(1, 0), 0);
        step(0, OP_LW, 0, 1, "LW.WB", 3'd4, cWB(0, 1), 1);

        // SW with one fetch wait state
        step(0, OP_SW, 0, 0, "SW.IFw", 3'd0, cIF(0), 0);
        step(0, OP_SW, 0, 1, "SW.IF", 3'd0, cIF(1), 0);
        step(0, OP_SW, 0, 1, "SW.ID", 3'd1, cID(0, 0), 0);
        step(0, OP_SW, 0, 1, "SW.EX", 3'd2, cEX(2'b10, 3'b010, 1), 0);
        step(0, OP_SW, 0, 1, "SW.MEM", 3'd3, cMEM(0, 1), 1);

        step(0, OP_BEQ, 0, 1, "BEQt.IF", 3'd0, cIF(1), 0);
        step(0, OP_BEQ, 0, 1, "BEQt.ID", 3'd1, cID(0, 0), 0);
        step(0, OP_BEQ, 1, 1, "BEQt.EX", 3'd2, cBEQ(1), 1);
        step(0, OP_BEQ, 1, 1, "BEQn.IF", 3'd0, cIF(1), 0);
        step(0, OP_BEQ, 1, 1, "BEQn.ID", 3'd1, cID(0, 0), 0);
        step(0, OP_BEQ, 0, 1, "BEQn.EX", 3'd2, cBEQ(0), 1);

        step(0, OP_J, 0, 1, "J.IF", 3'd0, cIF(1), 0);
        step(0, OP_J, 0, 1, "J.ID", 3'd1, cID(1, 0), 1);
        step(0, OP_BAD, 0, 1, "BAD.IF", 3'd0, cIF(1), 0);
        step(0, OP_BAD, 0, 1, "BAD.ID", 3'd1, cID(0, 1), 0);
        step(0, OP_BAD, 0, 1, "BAD.next", 3'd0, cIF(1), 0);

        // Reset lands while SW waits in MEM
        step(0, OP_SW, 0, 1, "SWr.ID", 3'd1, cID(0, 0), 0);
        step(0, OP_SW, 0, 1, "SWr.EX", 3'd2, cEX(2'b10, 3'b010, 1), 0);
        step(0, OP_SW, 0, 0, "SWr.MEMw", 3'd3, cMEM(0, 1), 0);
        step(1, OP_SW, 0, 1, "SWr.rst", 3'd0, '0, 0);
        step(1, OP_SW, 0, 1, "SWr.rst2", 3'd0, '0, 0);

        // Five retiring R-types wrap the 2-bit counter: 1,2,3,0,1
        for (int i = 0; i < 5; i++) begin
            step(0, OP_R, 0, 1, $sformatf("wrap%0d.IF", i), 3'd0, cIF(1), 0);
            step(0, OP_R, 0, 1, $sformatf("wrap%0d.ID", i), 3'd1, cID(0, 0), 0);
            step(0, OP_R, 0, 1, $sformatf("wrap%0d.EX", i), 3'd2, cEX(2'b00, 3'b000, 0), 0);
            step(0, OP_R, 0, 1, $sformatf("wrap%0d.WB", i), 3'd4, cWB(1, 0), 1);
        end
        step(0, OP_R, 0, 0, "wrap.end", 3'd0, cIF(0), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle MIPS control unit: a state machine that sequences fetch, decode, execute, memory and write-back for the core's instruction subset. It replaces the single-cycle opcode decoder. Memory accesses use a ready handshake, so instruction and data memories may insert wait states. The block also flags illegal opcodes and counts retired instructions.

## Interface
- ALUOP_W, 3: width of `alu_op`. Must be ≥3; the 3-bit codes are zero-extended.
- CNT_W, 32: width of the retired-instruction counter.

- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  6  instr[31:26] from the instruction register; valid from ID onward
- zero  in  1  ALU zero flag, sampled in EX for BEQ
- mem_ready  in  1  memory access completes this cycle
- pc_write  out  1  PC load strobe
- pc_src  out  2  PC source: 00 ALU result (PC+4), 01 ALUOut (branch target), 10 jump target
- ir_write  out  1  instruction register load strobe
- i_or_d  out  1  memory address select: 0 PC, 1 ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- reg_dst  out  1  write-register select: 1 rd, 0 rt
- mem_to_reg  out  1  write-back data select: 1 MDR, 0 ALUOut
- reg_write  out  1  register file write strobe
- alu_src_a  out  1  ALU A operand: 0 PC, 1 register rs
- alu_src_b  out  2  ALU B operand: 00 rt, 01 constant 4, 10 extended immediate, 11 extended immediate << 2
- alu_op  out  ALUOP_W  ALU operation
- ext_op  out  1  immediate extension: 1 sign, 0 zero
- state  out  3  current state: IF=0, ID=1, EX=2, MEM=3, WB=4
- illegal  out  1  one-cycle pulse on an unsupported opcode
- retired  out  CNT_W  count of completed instructions

## Operation
- Opcodes:
  - R-type 000000
  - ADDI 001000, ADDIU 001001
  - ORI 001101
  - LUI 001111
  - LW 100011
  - SW 101011
  - BEQ 000100
  - J 000010
  - Every other opcode is illegal.
- ALU op codes: 000 R-type (funct decides), 001 OR, 010 ADD, 100 LUI, 110 SUB.
- Output rule: all outputs are combinational functions of `state`, `opcode`, `zero` and `mem_ready`. Any output not listed for a state is 0.
- IF:
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=010.
  - When mem_ready=1: ir_write=1, pc_write=1, pc_src=00; next state ID.
  - Otherwise stay in IF.
- ID:
  - Outputs: alu_src_a=0, alu_src_b=11, ext_op=1, alu_op=010 (branch target is precomputed into ALUOut).
  - J: pc_write=1, pc_src=10; next IF; retires.
  - Illegal opcode: illegal=1, no write strobes; next IF; does not retire.
  - All other opcodes: next EX.
- EX (alu_src_a=1 for all opcodes):
  - R-type: alu_src_b=00, alu_op=000; next WB.
  - ADDI/ADDIU: alu_src_b=10, ext_op=1, alu_op=010; next WB.
  - ORI: alu_src_b=10, ext_op=0, alu_op=001; next WB.
  - LUI: alu_src_b=10, ext_op=0, alu_op=100; next WB.
  - LW/SW: alu_src_b=10, ext_op=1, alu_op=010; next MEM.
  - BEQ: alu_src_b=00, alu_op=110, pc_src=01, pc_write=zero; next IF; retires whether or not the branch is taken.
- MEM:
  - Outputs: i_or_d=1; mem_read=1 for LW, mem_write=1 for SW. The request is held until mem_ready=1.
  - On mem_ready=1: SW goes to IF and retires; LW goes to WB.
  - Otherwise stay in MEM.
- WB:
  - Outputs: reg_write=1; reg_dst=1 for R-type; mem_to_reg=1 for LW.
  - Next IF; retires.
- Retire counter: `retired` increments by 1 on the clock edge of each retiring transition. It wraps from 2^CNT_W−1 to 0 with no flag.

## Timing
- Reset:
  - While rst=1: state=IF, retired=0, and every output is forced to 0, including the IF strobes.
  - When rst asserts mid-instruction, the instruction is abandoned with no retire and no further strobes.
  - After rst deasserts, the first IF begins on the next cycle.
- Cycle counts with zero-wait memory (mem_ready held 1):

  | Instruction | Cycles |
  |---|---|
  | J | 2 |
  | Illegal opcode | 2 |
  | BEQ | 3 |
  | R-type, ALU-immediate | 4 |
  | SW | 4 |
  | LW | 5 |

- Each cycle with mem_ready=0 in IF or MEM adds one cycle.
- Handshake rules:
  - mem_read and mem_write stay stable while waiting.
  - Exactly one ir_write per fetch.
  - mem_write is never high outside MEM.
- `zero` is used only in EX for BEQ. `mem_ready` is ignored outside IF and MEM.
- Strobes are single-cycle, except mem_read and mem_write during wait states.

## Test plan
- Reset release, mem_ready=1, opcode=000000:
  - State sequence 0,1,2,4,0.
  - reg_write=1 and reg_dst=1 only in WB.
  - retired goes 0→1.
- LW (100011) with mem_ready low for 2 cycles in MEM:
  - MEM lasts 3 cycles with mem_read=1 and i_or_d=1 throughout.
  - WB asserts mem_to_reg=1 and reg_write=1.
  - Total 7 cycles.
- BEQ (000100):
  - zero=1: pc_write=1 and pc_src=01 in EX.
  - zero=0: pc_write=0.
  - Both cases return to IF after 3 cycles, and retired increments both times.
- J (000010) followed by opcode 111111:
  - J: pc_src=10 and pc_write=1 in ID.
  - Illegal opcode: illegal pulses for 1 cycle in ID and retired is unchanged.
- rst asserted while in MEM with SW pending:
  - mem_write drops immediately and state=0.
  - retired is not incremented.
- CNT_W=2, five WB-retiring instructions: retired reads 1,2,3,0,1.
